// File: rtl/game_pkg.sv
// Shared game-level constants and types used by the collision detector and its
// frame-overlap accumulator.
package game_pkg;

  localparam logic [1:0] UnBegin = 2'b00;
  localparam logic [1:0] Running = 2'b01;
  localparam logic [1:0] Dead    = 2'b10;

  localparam int ScreenW = 640;
  localparam int ScreenH = 480;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    SCAN,
    REPORT,
    WAIT_CLEAR
  } cd_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/overlap_accum.sv
// Per-frame saturating overlap counter with capture of the frame's first
// overlap location and obstacle selector.
module overlap_accum
  import game_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        overlap_i,
  input  logic        frame_end_i,
  input  logic [9:0]  xx_i,
  input  logic [8:0]  yy_i,
  input  logic [3:0]  sel_i,
  output logic [15:0] total_o,
  output logic [9:0]  first_x_o,
  output logic [8:0]  first_y_o,
  output logic [3:0]  first_sel_o
);

  logic [15:0] cnt_q, cnt_d;
  logic [9:0]  px_q, px_d;
  logic [8:0]  py_q, py_d;
  logic [3:0]  psel_q, psel_d;
  logic        first_now;

  assign first_now = overlap_i && (cnt_q == 16'd0);

  // The frame-end pixel itself may be the first overlap, so expose it directly.
  assign total_o     = overlap_i ? sat_inc16(cnt_q) : cnt_q;
  assign first_x_o   = first_now ? xx_i  : px_q;
  assign first_y_o   = first_now ? yy_i  : py_q;
  assign first_sel_o = first_now ? sel_i : psel_q;

  always_comb begin
    cnt_d  = cnt_q;
    px_d   = px_q;
    py_d   = py_q;
    psel_d = psel_q;
    if (clear_i) begin
      cnt_d = 16'd0;
    end else begin
      if (first_now) begin
        px_d   = xx_i;
        py_d   = yy_i;
        psel_d = sel_i;
      end
      if (frame_end_i) begin
        cnt_d = 16'd0;
      end else if (overlap_i) begin
        cnt_d = sat_inc16(cnt_q);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= 16'd0;
      px_q   <= 10'd0;
      py_q   <= 9'd0;
      psel_q <= 4'd0;
    end else begin
      cnt_q  <= cnt_d;
      px_q   <= px_d;
      py_q   <= py_d;
      psel_q <= psel_d;
    end
  end

endmodule

// File: rtl/collision_detector.sv
// Counts dino/obstacle overlap per frame while Running and raises a held
// collision request after enough consecutive hit frames.
module collision_detector
  import game_pkg::*;
#(
  parameter int HitThreshold  = 4,
  parameter int ConfirmFrames = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  gamestate,
  input  logic [9:0]  xx,
  input  logic [8:0]  yy,
  input  logic        pix_valid,
  input  logic        isemptyDino,
  input  logic        isemptyObstacle,
  input  logic [3:0]  OBSSEL,
  input  logic        collide_ack,
  output logic        collide,
  output logic [15:0] hit_count,
  output logic [9:0]  hit_x,
  output logic [8:0]  hit_y,
  output logic [3:0]  hit_sel
);

  cd_state_t   state_q, state_d;
  logic [3:0]  confirm_q, confirm_d, confirm_next;
  logic        collide_q, collide_d;
  logic [15:0] hit_count_q, hit_count_d;
  logic [9:0]  hit_x_q, hit_x_d;
  logic [8:0]  hit_y_q, hit_y_d;
  logic [3:0]  hit_sel_q, hit_sel_d;

  logic        running, visible, overlap, frame_end, acc_clear;
  logic [15:0] total;
  logic [9:0]  first_x;
  logic [8:0]  first_y;
  logic [3:0]  first_sel;

  assign running   = (gamestate == Running);
  assign visible   = pix_valid && (xx < 10'(ScreenW)) && (yy < 9'(ScreenH));
  assign overlap   = visible && !isemptyDino && !isemptyObstacle;
  assign frame_end = visible && (xx == 10'(ScreenW - 1)) && (yy == 9'(ScreenH - 1));
  // Only SCAN accumulates; any other state keeps the frame counter empty.
  assign acc_clear = (state_q != SCAN) || !running;

  overlap_accum u_accum (
    .clk_i       (clk),
    .rst_i       (rst),
    .clear_i     (acc_clear),
    .overlap_i   (overlap),
    .frame_end_i (frame_end),
    .xx_i        (xx),
    .yy_i        (yy),
    .sel_i       (OBSSEL),
    .total_o     (total),
    .first_x_o   (first_x),
    .first_y_o   (first_y),
    .first_sel_o (first_sel)
  );

  assign confirm_next = (total >= 16'(HitThreshold)) ? confirm_q + 4'd1 : 4'd0;

  always_comb begin
    state_d     = state_q;
    confirm_d   = confirm_q;
    collide_d   = collide_q;
    hit_count_d = hit_count_q;
    hit_x_d     = hit_x_q;
    hit_y_d     = hit_y_q;
    hit_sel_d   = hit_sel_q;
    case (state_q)
      IDLE: begin
        confirm_d = 4'd0;
        if (running) state_d = SYNC;
      end
      SYNC: begin
        if (!running)       state_d = IDLE;
        else if (frame_end) state_d = SCAN;
      end
      SCAN: begin
        if (!running) begin
          state_d   = IDLE;
          confirm_d = 4'd0;
        end else if (frame_end) begin
          hit_count_d = total;
          if (confirm_next == 4'(ConfirmFrames)) begin
            state_d   = REPORT;
            collide_d = 1'b1;
            hit_x_d   = first_x;
            hit_y_d   = first_y;
            hit_sel_d = first_sel;
            confirm_d = 4'd0;
          end else begin
            confirm_d = confirm_next;
          end
        end
      end
      REPORT: begin
        if (collide_ack) begin
          collide_d = 1'b0;
          state_d   = WAIT_CLEAR;
        end
      end
      WAIT_CLEAR: begin
        if (!running) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      confirm_q   <= 4'd0;
      collide_q   <= 1'b0;
      hit_count_q <= 16'd0;
      hit_x_q     <= 10'd0;
      hit_y_q     <= 9'd0;
      hit_sel_q   <= 4'd0;
    end else begin
      state_q     <= state_d;
      confirm_q   <= confirm_d;
      collide_q   <= collide_d;
      hit_count_q <= hit_count_d;
      hit_x_q     <= hit_x_d;
      hit_y_q     <= hit_y_d;
      hit_sel_q   <= hit_sel_d;
    end
  end

  assign collide   = collide_q;
  assign hit_count = hit_count_q;
  assign hit_x     = hit_x_q;
  assign hit_y     = hit_y_q;
  assign hit_sel   = hit_sel_q;

endmodule

// File: tb/tb_collision_detector.sv
// Bench for collision_detector: two instances (ConfirmFrames 1 and 2) share
// stimulus; a frame-level model predicts every output each cycle.
module tb_collision_detector;
  import game_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  gs;
  logic [9:0]  xx;
  logic [8:0]  yy;
  logic        pv, de, oe, ack;
  logic [3:0]  sel;

  logic        col_a, col_b;
  logic [15:0] hc_a, hc_b;
  logic [9:0]  hx_a, hx_b;
  logic [8:0]  hy_a, hy_b;
  logic [3:0]  hs_a, hs_b;

  always #5 clk = ~clk;

  collision_detector #(.HitThreshold(4), .ConfirmFrames(1)) dut_a (
    .clk(clk), .rst(rst), .gamestate(gs), .xx(xx), .yy(yy), .pix_valid(pv),
    .isemptyDino(de), .isemptyObstacle(oe), .OBSSEL(sel), .collide_ack(ack),
    .collide(col_a), .hit_count(hc_a), .hit_x(hx_a), .hit_y(hy_a), .hit_sel(hs_a));

  collision_detector #(.HitThreshold(4), .ConfirmFrames(2)) dut_b (
    .clk(clk), .rst(rst), .gamestate(gs), .xx(xx), .yy(yy), .pix_valid(pv),
    .isemptyDino(de), .isemptyObstacle(oe), .OBSSEL(sel), .collide_ack(ack),
    .collide(col_b), .hit_count(hc_b), .hit_x(hx_b), .hit_y(hy_b), .hit_sel(hs_b));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: modes describe what the detector is doing, frame data is
  // kept as an unbounded pixel count plus the first overlapping pixel.
  localparam int M_OFF = 0, M_WAITFRAME = 1, M_COUNT = 2, M_FIRED = 3, M_HOLDOFF = 4;
  int cfv [2] = '{1, 2};
  int mode [2];
  int npix [2];
  int streak [2];
  bit got [2];
  int fx [2], fy [2], fs [2];
  int e_col [2], e_hc [2], e_hx [2], e_hy [2], e_hs [2];

  task automatic model_step(input int i);
    bit vis, ov, fe, run;
    int total;
    if (rst) begin
      mode[i] = M_OFF; npix[i] = 0; streak[i] = 0; got[i] = 0;
      fx[i] = 0; fy[i] = 0; fs[i] = 0;
      e_col[i] = 0; e_hc[i] = 0; e_hx[i] = 0; e_hy[i] = 0; e_hs[i] = 0;
      return;
    end
    vis = pv && (int'(xx) < ScreenW) && (int'(yy) < ScreenH);
    ov  = vis && !de && !oe;
    fe  = vis && (int'(xx) == ScreenW - 1) && (int'(yy) == ScreenH - 1);
    run = (gs == 2'b01);
    case (mode[i])
      M_OFF:       if (run) mode[i] = M_WAITFRAME;
      M_WAITFRAME: if (!run) mode[i] = M_OFF;
                   else if (fe) begin
                     mode[i] = M_COUNT; npix[i] = 0; got[i] = 0; streak[i] = 0;
                   end
      M_COUNT: begin
        if (!run) begin
          mode[i] = M_OFF; npix[i] = 0; got[i] = 0; streak[i] = 0;
        end else begin
          if (ov) begin
            if (!got[i]) begin fx[i] = xx; fy[i] = yy; fs[i] = sel; got[i] = 1; end
            npix[i]++;
          end
          if (fe) begin
            total = (npix[i] > 65535) ? 65535 : npix[i];
            e_hc[i] = total;
            streak[i] = (total >= 4) ? streak[i] + 1 : 0;
            if (streak[i] == cfv[i]) begin
              e_col[i] = 1; e_hx[i] = fx[i]; e_hy[i] = fy[i]; e_hs[i] = fs[i];
              mode[i] = M_FIRED; streak[i] = 0;
            end
            npix[i] = 0; got[i] = 0;
          end
        end
      end
      M_FIRED:   if (ack) begin e_col[i] = 0; mode[i] = M_HOLDOFF; end
      M_HOLDOFF: if (!run) mode[i] = M_OFF;
      default:   mode[i] = M_OFF;
    endcase
  endtask

  task automatic step(input logic r, input logic [1:0] g, input logic [9:0] x,
                      input logic [8:0] y, input logic v, input logic d,
                      input logic o, input logic [3:0] s, input logic a);
    rst = r; gs = g; xx = x; yy = y; pv = v; de = d; oe = o; sel = s; ack = a;
    @(posedge clk);
    model_step(0);
    model_step(1);
    #1;
    check("collide_a", col_a, e_col[0]);   check("hit_count_a", hc_a, e_hc[0]);
    check("hit_x_a", hx_a, e_hx[0]);       check("hit_y_a", hy_a, e_hy[0]);
    check("hit_sel_a", hs_a, e_hs[0]);
    check("collide_b", col_b, e_col[1]);   check("hit_count_b", hc_b, e_hc[1]);
    check("hit_x_b", hx_b, e_hx[1]);       check("hit_y_b", hy_b, e_hy[1]);
    check("hit_sel_b", hs_b, e_hs[1]);
  endtask

  task automatic do_rst();                 step(1, 2'b00, 0, 0, 0, 1, 1, 0, 0); endtask
  task automatic idle(input logic [1:0] g); step(0, g, 0, 0, 0, 1, 1, 0, 0); endtask
  task automatic ovl(input logic [1:0] g, input int x, input int y, input int s);
    step(0, g, 10'(x), 9'(y), 1, 0, 0, 4'(s), 0);
  endtask
  task automatic fend(input logic [1:0] g); step(0, g, 639, 479, 1, 1, 0, 0, 0); endtask
  task automatic frame(input int n, input int x0, input int y0, input int s);
    for (int k = 0; k < n; k++) ovl(2'b01, x0 + k, y0, s);
    step(0, 2'b01, 300, 300, 1, 0, 1, 0, 0);
    fend(2'b01);
  endtask

  typedef struct {
    logic r; logic [1:0] g; logic [9:0] x; logic [8:0] y;
    logic v, d, o; logic [3:0] s; logic a;
    logic ec; logic [15:0] ehc; logic [9:0] ehx; logic [8:0] ehy; logic [3:0] ehs;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic [1:0] g, logic [9:0] x, logic [8:0] y,
                              logic v, logic d, logic o, logic [3:0] s, logic a,
                              logic ec, logic [15:0] ehc, logic [9:0] ehx,
                              logic [8:0] ehy, logic [3:0] ehs);
    vec_t t;
    t.r = r; t.g = g; t.x = x; t.y = y; t.v = v; t.d = d; t.o = o; t.s = s; t.a = a;
    t.ec = ec; t.ehc = ehc; t.ehx = ehx; t.ehy = ehy; t.ehs = ehs;
    return t;
  endfunction

  initial begin
    // Single-hit scenario on the ConfirmFrames=1 instance.
    tbl.push_back(mk(1, 0, 0, 0, 0, 1, 1, 0, 0,   0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 1, 0, 0,   0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 639, 479, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 6; k++)
      tbl.push_back(mk(0, 1, 10'(100 + k), 102, 1, 0, 0, 3, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 639, 479, 1, 1, 0, 0, 0, 1, 6, 100, 102, 3));
    for (int k = 0; k < 10; k++)
      tbl.push_back(mk(0, 1, 0, 0, 0, 1, 1, 0, 0, 1, 6, 100, 102, 3));
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 1, 0, 1,   0, 6, 100, 102, 3));
    tbl.push_back(mk(0, 1, 0, 0, 0, 1, 1, 0, 0,   0, 6, 100, 102, 3));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].r, tbl[i].g, tbl[i].x, tbl[i].y, tbl[i].v, tbl[i].d, tbl[i].o,
           tbl[i].s, tbl[i].a);
      check("tbl_collide", col_a, tbl[i].ec);
      check("tbl_hit_count", hc_a, tbl[i].ehc);
      check("tbl_hit_x", hx_a, tbl[i].ehx);
      check("tbl_hit_y", hy_a, tbl[i].ehy);
      check("tbl_hit_sel", hs_a, tbl[i].ehs);
    end

    // Running with no overlap, then frames just below threshold.
    do_rst(); idle(1); fend(1);
    for (int f = 0; f < 3; f++) begin
      frame(0, 0, 0, 0);
      check("noov_hit_count", hc_a, 0);
      check("noov_collide", col_a, 0);
    end
    for (int f = 0; f < 2; f++) begin
      frame(3, 10, 20, 5);
      check("below_hit_count", hc_a, 3);
      check("below_collide_a", col_a, 0);
      check("below_collide_b", col_b, 0);
    end

    // Overlap while waiting for the first full frame is ignored; then 5,0,5,5.
    do_rst(); idle(1);
    for (int k = 0; k < 5; k++) ovl(1, 50 + k, 60, 7);
    fend(1);
    frame(0, 0, 0, 0);
    check("sync_hit_count_b", hc_b, 0);
    frame(5, 200, 51, 1); check("cf2_f1_collide_b", col_b, 0);
    frame(0, 0, 0, 0);    check("cf2_f2_collide_b", col_b, 0);
    frame(5, 200, 53, 3); check("cf2_f3_collide_b", col_b, 0);
    frame(5, 210, 54, 4);
    check("cf2_f4_collide_b", col_b, 1);
    check("cf2_hit_count_b", hc_b, 5);
    check("cf2_hit_x_b", hx_b, 210);
    check("cf2_hit_y_b", hy_b, 54);
    check("cf2_hit_sel_b", hs_b, 4);

    // Leaving Running mid-frame aborts the frame; re-entry waits for a frame end.
    do_rst(); idle(1); fend(1);
    ovl(1, 5, 5, 2); ovl(1, 6, 5, 2);
    idle(2); check("dead_collide", col_a, 0);
    idle(2); idle(1);
    for (int k = 0; k < 4; k++) ovl(1, 70 + k, 80, 9);
    fend(1);
    check("reentry_hit_count", hc_a, 0);
    check("reentry_collide", col_a, 0);
    frame(5, 400, 300, 6);
    check("reentry_fire", col_a, 1);
    check("reentry_hit_x", hx_a, 400);

    // Reset while collide is held clears everything.
    do_rst();
    check("rst_collide", col_a, 0); check("rst_hit_count", hc_a, 0);
    check("rst_hit_x", hx_a, 0);    check("rst_hit_y", hy_a, 0);
    check("rst_hit_sel", hs_a, 0);

    // After acknowledge, no re-fire until the game leaves Running.
    idle(1); fend(1); frame(5, 30, 40, 1);
    check("refire_first", col_a, 1);
    step(0, 1, 0, 0, 0, 1, 1, 0, 1);
    check("refire_ack", col_a, 0);
    for (int f = 0; f < 2; f++) begin
      frame(6, 30, 40, 1);
      check("refire_hold", col_a, 0);
    end
    idle(2); idle(1); fend(1); frame(5, 31, 41, 2);
    check("refire_after_leave", col_a, 1);

    // Randomized traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      logic        r, v, d, o, a;
      logic [1:0]  g;
      logic [9:0]  x;
      logic [8:0]  y;
      int          pick;
      r = ($urandom_range(0, 399) == 0);
      pick = $urandom_range(0, 29);
      g = (pick == 0) ? 2'b00 : (pick == 1) ? 2'b10 : 2'b01;
      if ($urandom_range(0, 15) == 0) begin
        x = 10'd639; y = 9'd479;
      end else if ($urandom_range(0, 7) == 0) begin
        x = 10'($urandom_range(0, 1023)); y = 9'($urandom_range(0, 511));
      end else begin
        x = 10'($urandom_range(0, 639)); y = 9'($urandom_range(0, 479));
      end
      v = ($urandom_range(0, 7) != 0);
      d = 1'($urandom_range(0, 1));
      o = 1'($urandom_range(0, 1));
      a = ($urandom_range(0, 9) == 0);
      step(r, g, x, y, v, d, o, 4'($urandom_range(0, 15)), a);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
